// File: rtl/vending_controller_pkg.sv
// Shared definitions for the vending controller: coin values, default prices,
// credit width and ceiling, FSM state encoding and the front-panel input bundle.
// Ports: none (package).
package vending_controller_pkg;

  localparam int CREDIT_W       = 10;
  localparam int DEF_MAX_CREDIT = 1000;

  localparam int COIN_QUARTER = 25;
  localparam int COIN_DIME    = 10;
  localparam int COIN_NICKEL  = 5;

  localparam int DEF_PRICE1 = 125;
  localparam int DEF_PRICE2 = 220;
  localparam int DEF_PRICE3 = 175;
  localparam int DEF_PRICE4 = 310;

  typedef logic [CREDIT_W-1:0] credit_t;
  // One extra bit so that credit + coins can be compared against the ceiling.
  typedef logic [CREDIT_W:0]   sum_t;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, GAP} state_t;

  // Front-panel inputs; bev[0] is beverage 1.
  typedef struct packed {
    logic       reset_count;
    logic       cancel;
    logic [3:0] bev;
    logic       nickel;
    logic       dime;
    logic       quarter;
  } panel_t;

endpackage

// File: rtl/vending_controller_if.sv
// Front-panel / actuator bundle of the vending controller.
// master: the panel side (drives coins, buttons; receives dispense/return pulses).
// slave:  the controller side.
interface vending_controller_if;
  logic inQuarter, inDime, inNickel;
  logic inbev1, inbev2, inbev3, inbev4;
  logic cancel, resetCount;
  logic outbev1, outbev2, outbev3, outbev4;
  logic outquarter, outdime, outnickel;

  modport master (
    output inQuarter, inDime, inNickel, inbev1, inbev2, inbev3, inbev4,
           cancel, resetCount,
    input  outbev1, outbev2, outbev3, outbev4, outquarter, outdime, outnickel
  );

  modport slave (
    input  inQuarter, inDime, inNickel, inbev1, inbev2, inbev3, inbev4,
           cancel, resetCount,
    output outbev1, outbev2, outbev3, outbev4, outquarter, outdime, outnickel
  );
endinterface

// File: rtl/vending_controller_change_dispenser.sv
// Greedy coin-return selector: picks the largest coin not exceeding credit.
// Latency: combinational; the top registers the pulse and the reduced credit.
// Ports: credit in; give_quarter/give_dime/give_nickel and credit_after out.
module change_dispenser
  import vending_controller_pkg::*;
(
  input  credit_t credit,
  output logic    give_quarter,
  output logic    give_dime,
  output logic    give_nickel,
  output credit_t credit_after
);

  always_comb begin
    give_quarter = 1'b0;
    give_dime    = 1'b0;
    give_nickel  = 1'b0;
    credit_after = credit;
    if (credit >= credit_t'(COIN_QUARTER)) begin
      give_quarter = 1'b1;
      credit_after = credit - credit_t'(COIN_QUARTER);
    end else if (credit >= credit_t'(COIN_DIME)) begin
      give_dime    = 1'b1;
      credit_after = credit - credit_t'(COIN_DIME);
    end else if (credit >= credit_t'(COIN_NICKEL)) begin
      give_nickel  = 1'b1;
      credit_after = credit - credit_t'(COIN_NICKEL);
    end
  end

endmodule

// File: rtl/vending_controller.sv
// Vending controller: edge-detects panel inputs, accumulates credit, vends and returns change.
// Latency: dispense pulse one cycle after the selecting edge; change coins every second cycle.
// Ports: clk, rst (sync, active-high), bus (panel inputs in, registered actuator pulses out).
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int PRICE1     = DEF_PRICE1,
  parameter int PRICE2     = DEF_PRICE2,
  parameter int PRICE3     = DEF_PRICE3,
  parameter int PRICE4     = DEF_PRICE4,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
)
(
  input logic                 clk,
  input logic                 rst,
  vending_controller_if.slave bus
);

  state_t  state, state_nxt;
  credit_t credit, credit_nxt, credit_in;
  panel_t  in_now, in_prev, in_edge;
  sum_t    coin_sum;

  logic [3:0] bev_q, bev_nxt;
  logic       quarter_q, dime_q, nickel_q;
  logic       quarter_nxt, dime_nxt, nickel_nxt;

  logic [3:0] sel_bev;
  credit_t    sel_price;

  logic    give_quarter, give_dime, give_nickel;
  credit_t credit_after;

  assign in_now = '{reset_count: bus.resetCount,
                    cancel:      bus.cancel,
                    bev:         {bus.inbev4, bus.inbev3, bus.inbev2, bus.inbev1},
                    nickel:      bus.inNickel,
                    dime:        bus.inDime,
                    quarter:     bus.inQuarter};

  assign in_edge = in_now & ~in_prev;

  // Coins arriving together are summed; the whole batch is refused if it would
  // push credit over the ceiling.
  assign coin_sum = sum_t'(credit)
                  + (in_edge.quarter ? sum_t'(COIN_QUARTER) : sum_t'(0))
                  + (in_edge.dime    ? sum_t'(COIN_DIME)    : sum_t'(0))
                  + (in_edge.nickel  ? sum_t'(COIN_NICKEL)  : sum_t'(0));
  assign credit_in = (coin_sum <= sum_t'(MAX_CREDIT)) ? credit_t'(coin_sum) : credit;

  // Lowest-numbered button wins when several are pressed together.
  always_comb begin
    sel_bev   = 4'b0000;
    sel_price = '0;
    if (in_edge.bev[0]) begin
      sel_bev = 4'b0001; sel_price = credit_t'(PRICE1);
    end else if (in_edge.bev[1]) begin
      sel_bev = 4'b0010; sel_price = credit_t'(PRICE2);
    end else if (in_edge.bev[2]) begin
      sel_bev = 4'b0100; sel_price = credit_t'(PRICE3);
    end else if (in_edge.bev[3]) begin
      sel_bev = 4'b1000; sel_price = credit_t'(PRICE4);
    end
  end

  change_dispenser u_change (
    .credit       (credit),
    .give_quarter (give_quarter),
    .give_dime    (give_dime),
    .give_nickel  (give_nickel),
    .credit_after (credit_after)
  );

  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit;
    bev_nxt     = 4'b0000;
    quarter_nxt = 1'b0;
    dime_nxt    = 1'b0;
    nickel_nxt  = 1'b0;
    case (state)
      IDLE: begin
        credit_nxt = credit_in;
        if (in_edge.cancel) begin
          state_nxt = CHANGE;
        end else if (sel_bev != 4'b0000) begin
          // An unaffordable selection is silently ignored.
          if (credit_in >= sel_price) begin
            credit_nxt = credit_in - sel_price;
            bev_nxt    = sel_bev;
            state_nxt  = VEND;
          end
        end else if (in_edge.reset_count) begin
          credit_nxt = '0;
        end
      end
      VEND: state_nxt = CHANGE;
      CHANGE: begin
        if (give_quarter || give_dime || give_nickel) begin
          credit_nxt  = credit_after;
          quarter_nxt = give_quarter;
          dime_nxt    = give_dime;
          nickel_nxt  = give_nickel;
          state_nxt   = GAP;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP:     state_nxt = CHANGE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input history keeps tracking outside IDLE so edges there are discarded, not deferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      credit    <= '0;
      in_prev   <= '0;
      bev_q     <= 4'b0000;
      quarter_q <= 1'b0;
      dime_q    <= 1'b0;
      nickel_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      credit    <= credit_nxt;
      in_prev   <= in_now;
      bev_q     <= bev_nxt;
      quarter_q <= quarter_nxt;
      dime_q    <= dime_nxt;
      nickel_q  <= nickel_nxt;
    end
  end

  assign bus.outbev1    = bev_q[0];
  assign bus.outbev2    = bev_q[1];
  assign bus.outbev3    = bev_q[2];
  assign bus.outbev4    = bev_q[3];
  assign bus.outquarter = quarter_q;
  assign bus.outdime    = dime_q;
  assign bus.outnickel  = nickel_q;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios plus random coin
// streams, compared against a credit/greedy-change model and an expected pulse list.
// Ports: none (top-level bench).
module tb_vending_controller;

  // Stimulus mask bits
  localparam int M_Q = 1, M_D = 2, M_N = 4;
  localparam int M_B1 = 8, M_B2 = 16, M_B3 = 32, M_B4 = 64;
  localparam int M_CANCEL = 128, M_RSTCNT = 256;
  // Event codes: 0..3 = bev1..bev4, 4 = quarter, 5 = dime, 6 = nickel
  localparam int E_Q = 4, E_D = 5, E_N = 6;

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vending_controller_if vif();

  vending_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  int   cyc = 0;
  ev_t  evq[$];
  int   exp_codes[$];
  int   ref_credit = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  // Record every output pulse, one entry per high cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (vif.outbev1)    evq.push_back('{0, cyc});
    if (vif.outbev2)    evq.push_back('{1, cyc});
    if (vif.outbev3)    evq.push_back('{2, cyc});
    if (vif.outbev4)    evq.push_back('{3, cyc});
    if (vif.outquarter) evq.push_back('{E_Q, cyc});
    if (vif.outdime)    evq.push_back('{E_D, cyc});
    if (vif.outnickel)  evq.push_back('{E_N, cyc});
  end

  function automatic logic [6:0] outs();
    return {vif.outbev1, vif.outbev2, vif.outbev3, vif.outbev4,
            vif.outquarter, vif.outdime, vif.outnickel};
  endfunction

  // True when the recorded pulses equal the expected list and no two pulses
  // fall on adjacent cycles (every pulse is one cycle, separated by a low cycle).
  function automatic bit seq_match();
    if (evq.size() != exp_codes.size()) return 1'b0;
    foreach (evq[i]) begin
      if (evq[i].code != exp_codes[i]) return 1'b0;
      if (i > 0 && (evq[i].cyc - evq[i-1].cyc) < 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(input int mask);
    vif.inQuarter  = mask[0];
    vif.inDime     = mask[1];
    vif.inNickel   = mask[2];
    vif.inbev1     = mask[3];
    vif.inbev2     = mask[4];
    vif.inbev3     = mask[5];
    vif.inbev4     = mask[6];
    vif.cancel     = mask[7];
    vif.resetCount = mask[8];
  endtask

  task automatic press(input int mask);
    @(negedge clk);
    drive(mask);
    @(negedge clk);
    drive(0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: coins seen together are added as a batch unless the ceiling is exceeded.
  task automatic insert(input int mask, input int times);
    int add;
    add = (mask[0] ? 25 : 0) + (mask[1] ? 10 : 0) + (mask[2] ? 5 : 0);
    repeat (times) begin
      press(mask);
      if (ref_credit + add <= 1000) ref_credit = ref_credit + add;
    end
  endtask

  task automatic expect_change(input int c);
    repeat (c / 25) exp_codes.push_back(E_Q);
    repeat ((c % 25) / 10) exp_codes.push_back(E_D);
    repeat ((c % 25 % 10) / 5) exp_codes.push_back(E_N);
  endtask

  task automatic begin_scn();
    evq.delete();
    exp_codes.delete();
  endtask

  task automatic test_reset();
    drive(0);
    rst = 1'b1;
    idle(3);
    chk_cnt++;
    if (outs() !== 7'b0) $display("FAIL reset_outputs got=%b want=%b", outs(), 7'b0);
    else pass_cnt++;
    rst = 1'b0;
    ref_credit = 0;
    begin_scn();
    press(M_CANCEL);
    idle(10);
    chk_cnt++;
    if (evq.size() !== 0) $display("FAIL reset_credit_zero got=%0d pulses want=0", evq.size());
    else pass_cnt++;
  endtask

  task automatic test_vend(input string name, input int qn, input int dn, input int nn,
                           input int bev, input int price);
    begin_scn();
    insert(M_Q, qn);
    insert(M_D, dn);
    insert(M_N, nn);
    exp_codes.push_back(bev);
    expect_change(ref_credit - price);
    press(M_B1 << bev);
    ref_credit = 0;
    idle(100);
    chk_cnt++;
    if (seq_match() !== 1'b1)
      $display("FAIL %s_sequence got=%0d pulses want=%0d", name, evq.size(), exp_codes.size());
    else pass_cnt++;
    // Back in IDLE with zero credit: one quarter in, one quarter back.
    begin_scn();
    insert(M_Q, 1);
    press(M_CANCEL);
    expect_change(25);
    ref_credit = 0;
    idle(20);
    chk_cnt++;
    if (seq_match() !== 1'b1)
      $display("FAIL %s_idle_after got=%0d pulses want=%0d", name, evq.size(), exp_codes.size());
    else pass_cnt++;
  endtask

  task automatic test_cancel_order();
    begin_scn();
    insert(M_Q, 1);
    insert(M_D, 1);
    insert(M_N, 1);
    press(M_CANCEL);
    exp_codes = '{E_Q, E_D, E_N};
    ref_credit = 0;
    idle(30);
    chk_cnt++;
    if (seq_match() !== 1'b1)
      $display("FAIL cancel_order got=%0d pulses want=3", evq.size());
    else pass_cnt++;
  endtask

  task automatic test_insufficient();
    begin_scn();
    insert(M_Q, 8);
    press(M_B4);
    idle(20);
    chk_cnt++;
    if (evq.size() !== 0) $display("FAIL insufficient_no_pulse got=%0d pulses want=0", evq.size());
    else pass_cnt++;
    press(M_CANCEL);
    expect_change(ref_credit);
    ref_credit = 0;
    idle(40);
    chk_cnt++;
    if (seq_match() !== 1'b1)
      $display("FAIL insufficient_credit_kept got=%0d pulses want=%0d", evq.size(), exp_codes.size());
    else pass_cnt++;
  endtask

  task automatic test_cancel_priority();
    begin_scn();
    insert(M_Q, 6);
    press(M_CANCEL | M_B1);
    expect_change(ref_credit);
    ref_credit = 0;
    idle(40);
    chk_cnt++;
    if (seq_match() !== 1'b1)
      $display("FAIL cancel_priority got=%0d pulses want=%0d", evq.size(), exp_codes.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_count();
    begin_scn();
    insert(M_Q, 3);
    press(M_RSTCNT);
    ref_credit = 0;
    press(M_CANCEL);
    idle(20);
    chk_cnt++;
    if (evq.size() !== 0) $display("FAIL reset_count got=%0d pulses want=0", evq.size());
    else pass_cnt++;
  endtask

  task automatic test_held_level();
    begin_scn();
    @(negedge clk);
    drive(M_Q);
    idle(6);
    drive(0);
    press(M_CANCEL);
    expect_change(25);
    idle(20);
    chk_cnt++;
    if (seq_match() !== 1'b1)
      $display("FAIL held_level got=%0d pulses want=1", evq.size());
    else pass_cnt++;
  endtask

  task automatic test_ceiling();
    begin_scn();
    ref_credit = 0;
    insert(M_Q, 40);
    insert(M_N, 1);
    insert(M_Q | M_D, 1);
    press(M_CANCEL);
    expect_change(ref_credit);
    ref_credit = 0;
    idle(100);
    chk_cnt++;
    if (seq_match() !== 1'b1 || exp_codes.size() != 40)
      $display("FAIL ceiling got=%0d pulses want=40", evq.size());
    else pass_cnt++;
  endtask

  task automatic test_random_coins();
    for (int r = 0; r < 4; r++) begin
      begin_scn();
      ref_credit = 0;
      for (int k = 0; k < 45; k++) insert(int'($urandom_range(0, 7)), 1);
      press(M_CANCEL);
      expect_change(ref_credit);
      ref_credit = 0;
      idle(100);
      chk_cnt++;
      if (seq_match() !== 1'b1)
        $display("FAIL random_round%0d got=%0d pulses want=%0d", r, evq.size(), exp_codes.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_rst_mid_change();
    begin_scn();
    insert(M_Q, 8);
    press(M_CANCEL);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (outs() !== 7'b0) $display("FAIL rst_mid_change_outputs got=%b want=%b", outs(), 7'b0);
    else pass_cnt++;
    rst = 1'b0;
    ref_credit = 0;
    begin_scn();
    idle(20);
    press(M_CANCEL);
    idle(20);
    chk_cnt++;
    if (evq.size() !== 0) $display("FAIL rst_mid_change_credit got=%0d pulses want=0", evq.size());
    else pass_cnt++;
  endtask

  initial begin
    drive(0);
    test_reset();
    test_vend("bev1", 6, 0, 0, 0, 125);
    test_vend("bev2_exact", 8, 2, 0, 1, 220);
    test_vend("bev3", 8, 0, 0, 2, 175);
    test_vend("bev4", 12, 0, 3, 3, 310);
    test_cancel_order();
    test_insufficient();
    test_cancel_priority();
    test_reset_count();
    test_held_level();
    test_ceiling();
    test_random_coins();
    test_rst_mid_change();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
